// File: rtl/key_debounce.sv
// Per-channel push-button / switch debouncer with level, press, release
// and hold-to-repeat strobes, fed by an external two-flop synchroniser.
module key_debounce #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] sync_in,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] release_pulse,
    output logic [N-1:0] repeat_pulse
);

    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                         : REPEAT_PERIOD;
    localparam int CW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RW   = $clog2(RMAX) + 1;
    localparam bit REP_EN = (REPEAT_DELAY != 0);

    localparam logic [CW-1:0] D_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST =
        RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    typedef enum logic {
        PH_DELAY,
        PH_PERIOD
    } phase_t;

    for (genvar i = 0; i < N; i++) begin : g_ch
        state_t        r_state;
        phase_t        r_phase;
        logic [CW-1:0] r_cnt;
        logic [RW-1:0] r_rcnt;
        logic          r_level;
        logic          r_press;
        logic          r_release;
        logic          r_repeat;

        logic          w_raw;
        logic          w_last;
        logic          w_rep_hit;
        logic [RW-1:0] w_rcnt_nxt;
        phase_t        w_phase_nxt;

        assign w_raw = sync_in[i] ^ ACTIVE_LOW;

        // Next repeat-counter step, applied on every held cycle in PRESSED
        // and on the cycle a release glitch ends (count resumes, not restarts).
        always_comb begin
            w_last      = (r_phase == PH_DELAY) ? (r_rcnt == RD_LAST)
                                                : (r_rcnt == RP_LAST);
            w_rep_hit   = 1'b0;
            w_rcnt_nxt  = r_rcnt;
            w_phase_nxt = r_phase;
            if (REP_EN) begin
                if (w_last) begin
                    w_rep_hit   = 1'b1;
                    w_rcnt_nxt  = '0;
                    w_phase_nxt = PH_PERIOD;
                end else if (r_rcnt != '1) begin
                    w_rcnt_nxt = r_rcnt + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_state   <= RELEASED;
                r_phase   <= PH_DELAY;
                r_cnt     <= '0;
                r_rcnt    <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_repeat  <= 1'b0;
            end else begin
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_repeat  <= 1'b0;
                unique case (r_state)
                    RELEASED: begin
                        if (w_raw) begin
                            r_state <= PRESS_WAIT;
                            r_cnt   <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!w_raw) begin
                            r_state <= RELEASED;
                            r_cnt   <= '0;
                        end else if (r_cnt == D_LAST) begin
                            r_state <= PRESSED;
                            r_level <= 1'b1;
                            r_press <= 1'b1;
                            r_rcnt  <= '0;
                            r_phase <= PH_DELAY;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (!w_raw) begin
                            r_state <= RELEASE_WAIT;
                            r_cnt   <= '0;
                        end else begin
                            r_rcnt   <= w_rcnt_nxt;
                            r_phase  <= w_phase_nxt;
                            r_repeat <= w_rep_hit;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (w_raw) begin
                            r_state  <= PRESSED;
                            r_rcnt   <= w_rcnt_nxt;
                            r_phase  <= w_phase_nxt;
                            r_repeat <= w_rep_hit;
                        end else if (r_cnt == D_LAST) begin
                            r_state   <= RELEASED;
                            r_level   <= 1'b0;
                            r_release <= 1'b1;
                            r_rcnt    <= '0;
                            r_phase   <= PH_DELAY;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_state <= RELEASED;
                endcase
            end
        end

        assign level[i]         = r_level;
        assign press[i]         = r_press;
        assign release_pulse[i] = r_release;
        assign repeat_pulse[i]  = r_repeat;
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: active-high build with repeat, and an
// active-low build with repeat disabled.
`timescale 1ns/1ps
module tb_key_debounce;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] a_in  = 2'b00;
    logic [1:0] b_in  = 2'b11;
    logic [1:0] a_lv, a_pr, a_rl, a_rp;
    logic [1:0] b_lv, b_pr, b_rl, b_rp;

    always #5 clk = ~clk;

    key_debounce #(
        .N(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10),
        .REPEAT_PERIOD(3), .ACTIVE_LOW(1'b0)
    ) u_a (
        .clk(clk), .reset(reset), .sync_in(a_in),
        .level(a_lv), .press(a_pr),
        .release_pulse(a_rl), .repeat_pulse(a_rp)
    );

    key_debounce #(
        .N(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0),
        .REPEAT_PERIOD(3), .ACTIVE_LOW(1'b1)
    ) u_b (
        .clk(clk), .reset(reset), .sync_in(b_in),
        .level(b_lv), .press(b_pr),
        .release_pulse(b_rl), .repeat_pulse(b_rp)
    );

    typedef struct packed {
        logic [1:0] in;
        logic [1:0] lv;
        logic [1:0] pr;
        logic [1:0] rl;
        logic [1:0] rp;
    } vec_t;

    vec_t sb_q[$];
    vec_t tbl[28];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic [1:0] in, lv, pr, rl, rp);
        return {in, lv, pr, rl, rp};
    endfunction

    task automatic chk(input string name, input logic [1:0] act,
                       input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input bit use_b,
                           input vec_t e);
        chk({tag, " level"},  use_b ? b_lv : a_lv, e.lv);
        chk({tag, " press"},  use_b ? b_pr : a_pr, e.pr);
        chk({tag, " release"}, use_b ? b_rl : a_rl, e.rl);
        chk({tag, " repeat"}, use_b ? b_rp : a_rp, e.rp);
    endtask

    task automatic step(input bit use_b, input string tag, input int t,
                        input vec_t v);
        vec_t e;
        if (use_b) b_in = v.in;
        else       a_in = v.in;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk_all($sformatf("%s[%0d]", tag, t), use_b, e);
    endtask

    task automatic do_reset(input logic [1:0] b_val);
        reset = 1'b0;
        a_in  = 2'b00;
        b_in  = b_val;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_all("reset_a", 1'b0, '0);
        chk_all("reset_b", 1'b1, {b_val, 8'b0});
        reset = 1'b1;
    endtask

    initial begin
        vec_t v;
        logic [1:0] zz;
        zz = 2'b00;

        // clean press + release on ch0 (rows 0-11)
        for (int r = 0; r < 4; r++) tbl[r] = mk(2'b01, zz, zz, zz, zz);
        tbl[4]  = mk(2'b01, 2'b01, 2'b01, zz, zz);
        tbl[5]  = mk(2'b01, 2'b01, zz, zz, zz);
        for (int r = 6; r < 10; r++) tbl[r] = mk(2'b00, 2'b01, zz, zz, zz);
        tbl[10] = mk(2'b00, zz, zz, 2'b01, zz);
        tbl[11] = mk(2'b00, zz, zz, zz, zz);
        // 4-sample glitch on ch0 (rows 12-17)
        for (int r = 12; r < 16; r++) tbl[r] = mk(2'b01, zz, zz, zz, zz);
        tbl[16] = mk(2'b00, zz, zz, zz, zz);
        tbl[17] = mk(2'b00, zz, zz, zz, zz);
        // short press on ch1 only (rows 18-27)
        for (int r = 18; r < 22; r++) tbl[r] = mk(2'b10, zz, zz, zz, zz);
        tbl[22] = mk(2'b10, 2'b10, 2'b10, zz, zz);
        for (int r = 23; r < 27; r++) tbl[r] = mk(2'b00, 2'b10, zz, zz, zz);
        tbl[27] = mk(2'b00, zz, zz, 2'b10, zz);

        do_reset(2'b11);
        for (int r = 0; r < 28; r++) step(1'b0, "table", r, tbl[r]);

        // auto-repeat: press at 4, repeats at 14/17/20, drop at 22
        for (int t = 0; t < 30; t++) begin
            v.in = (t <= 21) ? 2'b01 : 2'b00;
            v.lv = {1'b0, (t >= 4 && t < 26)};
            v.pr = {1'b0, t == 4};
            v.rl = {1'b0, t == 26};
            v.rp = {1'b0, (t == 14 || t == 17 || t == 20)};
            step(1'b0, "repeat", t, v);
        end

        // release glitch at 9..10 freezes the repeat count for 2 edges
        for (int t = 0; t < 32; t++) begin
            v.in = (t == 9 || t == 10 || t >= 24) ? 2'b00 : 2'b01;
            v.lv = {1'b0, (t >= 4 && t < 28)};
            v.pr = {1'b0, t == 4};
            v.rl = {1'b0, t == 28};
            v.rp = {1'b0, (t == 16 || t == 19 || t == 22)};
            step(1'b0, "relglitch", t, v);
        end

        // reset while held
        for (int t = 0; t < 7; t++) begin
            v.in = 2'b01;
            v.lv = {1'b0, t >= 4};
            v.pr = {1'b0, t == 4};
            v.rl = zz;
            v.rp = zz;
            step(1'b0, "prehold", t, v);
        end
        #2 reset = 1'b0;
        #1 chk_all("async_reset", 1'b0, {2'b01, 8'b0});
        @(posedge clk);
        #1 chk_all("in_reset", 1'b0, {2'b01, 8'b0});
        reset = 1'b1;
        for (int t = 0; t < 7; t++) begin
            v.in = 2'b01;
            v.lv = {1'b0, t >= 4};
            v.pr = {1'b0, t == 4};
            v.rl = zz;
            v.rp = zz;
            step(1'b0, "postreset", t, v);
        end

        // active-low build: ch0 pressed from reset release, 1-sample blip
        // at 10, released from 30; ch1 sees the synchroniser's reset zeros
        do_reset(2'b00);
        for (int t = 0; t < 40; t++) begin
            v.in[0] = (t == 10 || t >= 30);
            v.in[1] = (t >= 2);
            v.lv = {1'b0, (t >= 4 && t < 34)};
            v.pr = {1'b0, t == 4};
            v.rl = {1'b0, t == 34};
            v.rp = zz;
            step(1'b1, "actlow", t, v);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
# key_debounce

Per-channel debouncer for push-button and slide-switch inputs. It sits directly downstream of the two-flop input synchroniser and only accepts already-synchronised signals. For each channel it produces a clean level, one-cycle press and release strobes, and an optional hold-to-repeat strobe. These outputs drive the parameter-adjust and mode-select controls of the DSP datapath.

## Interface
Parameters:
- N, 4, number of independent channels.
- DEBOUNCE_CYCLES, 500000, consecutive-sample threshold D (10 ms at 50 MHz); must be ≥1.
- REPEAT_DELAY, 25000000, cycles RD held after the press strobe before the first repeat strobe; 0 disables repeat.
- REPEAT_PERIOD, 5000000, cycles RP between repeat strobes; must be ≥1.
- ACTIVE_LOW, 1, 1 = input low means asserted (DE1 KEYs); 0 = input high means asserted.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- sync_in  in  N  synchroniser outputs; the block applies no further synchronisation.
- level  out  N  debounced asserted level (1 = pressed/on).
- press  out  N  one-cycle strobe on the debounced 0→1 transition.
- release  out  N  one-cycle strobe on the debounced 1→0 transition.
- repeat_pulse  out  N  one-cycle auto-repeat strobe while held.

## Operation
- Per channel, raw = sync_in[i] XOR ACTIVE_LOW. All channels are independent and replicated logic.
- Per-channel state machine with four states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT. Each channel also has a debounce counter cnt and a repeat counter rcnt.
- Counter widths are $clog2 of their maximum count plus 1. Counters saturate and never wrap.
- RELEASED:
  - raw=1 → PRESS_WAIT, cnt=0.
  - raw=0 → stay.
- PRESS_WAIT:
  - raw=0 → RELEASED, cnt=0. A glitch aborts the wait with no strobe.
  - raw=1 and cnt==D-1 → PRESSED. level←1, press←1 for one cycle, rcnt=0, repeat phase=DELAY.
  - raw=1 otherwise → cnt++.
- PRESSED:
  - raw=0 → RELEASE_WAIT, cnt=0. rcnt is frozen.
  - raw=1 → repeat logic runs.
- Repeat logic (only when RD≠0):
  - DELAY phase: rcnt==RD-1 → repeat_pulse←1, rcnt=0, phase=PERIOD; otherwise rcnt++.
  - PERIOD phase: rcnt==RP-1 → repeat_pulse←1, rcnt=0; otherwise rcnt++.
- RELEASE_WAIT:
  - raw=1 → PRESSED. The repeat count resumes from its frozen value, with no strobe.
  - raw=0 and cnt==D-1 → RELEASED. level←0, release←1 for one cycle, rcnt and phase cleared.
  - raw=0 otherwise → cnt++.
- level holds its value in the WAIT states. The outputs press, release and repeat_pulse are mutually exclusive per channel in any cycle.
- Reset: all outputs 0, every channel in RELEASED, all counters 0.
  - The synchroniser also resets to 0. With ACTIVE_LOW=1 that reads as asserted until real input data reaches the synchroniser output 2 cycles later.
  - That brief assertion is far shorter than D, so it must not commit a press. D≥3 is required in ACTIVE_LOW=1 builds.
- Reset asserted mid-operation (any state) returns the channel to RELEASED immediately. No release strobe is produced.

## Timing
- All outputs are registered, so no combinational path runs from sync_in to any output.
- Press latency: level and press rise on the clock edge at which raw has been sampled asserted on D+1 consecutive edges (the entry edge plus D counting edges).
- Release latency is symmetric: D+1 consecutive deasserted samples.
- Glitch rejection: any run of ≤D consecutive samples is ignored.
- Repeat strobes, with the press strobe edge defined as E:
  - first repeat strobe at edge E+RD;
  - subsequent strobes at E+RD+k·RP for k≥1, while the input is continuously held.
- Strobes are exactly one cycle wide and are cleared on the next edge unless that edge re-triggers them, which is impossible for press and release.

## Test plan
Bench configuration: N=2, D=4, RD=10, RP=3, ACTIVE_LOW=0.
- Clean press: hold sync_in[0]=1 from edge 0 → level[0]=1 and press[0]=1 at edge 4 only; press[0]=0 at edge 5. Channel 1 stays 0.
- Glitch reject: pulse sync_in[0]=1 for 4 edges, then 0 → level, press and release remain 0 throughout.
- Auto-repeat: press committed at edge E, then hold → repeat_pulse[0] at E+10, E+13 and E+16. Release → release[0] 5 samples after the falling input, and no further repeat strobes.
- Release glitch while held: at edge E+5, drop the input for 2 edges, then reassert → level stays 1, no release strobe, and the repeat strobes shift 2 edges later (frozen count).
- Reset mid-hold: assert reset while level[0]=1 → all outputs 0 asynchronously. After deassert with the input still high, press[0] fires again after 5 samples.
- ACTIVE_LOW=1, D=4: drive sync_in=0 from reset release → press after 5 samples. A single 1-sample high blip during the hold produces no release strobe.
